// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered one-hot grant and a registered shared data mux.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD hold-timeout with forced rotation and the preempt pulse.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic [3:0] din_i,
  output logic [3:0] grant_o,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       dout_o,
  output logic       preempt_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter_4: MAX_HOLD must be within 2..255");
  end

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       dout_q, dout_d;
  logic [1:0] win;
  logic       new_grant;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       preempt_q, preempt_d;
`endif

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    win = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (|req_i) new_grant = 1'b1;
      BUSY: begin
        if (!req_i[sel_q]) begin
          if (|req_i) new_grant = 1'b1;
          else        state_d   = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == LIMIT) begin
          // ptr already points past the holder, so win is another requester when one exists.
          if (|(req_i & ~grant_q)) begin
            new_grant = 1'b1;
            preempt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (new_grant) begin
      state_d = BUSY;
      sel_d   = win;
      ptr_d   = win + 2'd1;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
    grant_d = (state_d == BUSY) ? (4'b0001 << sel_d) : 4'b0000;
    dout_d  = (state_d == BUSY) & din_i[sel_d];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      dout_q  <= dout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end
  assign preempt_o = preempt_q;
`else
  assign preempt_o = 1'b0;
`endif

  assign grant_o = grant_q;
  assign sel_o   = sel_q;
  assign busy_o  = (state_q == BUSY);
  assign dout_o  = dout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed vector table, corner sequences, random vs. reference model.
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, din;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy, dout, preempt;

  int nchk = 0;
  int nerr = 0;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .din_i(din),
    .grant_o(grant), .sel_o(sel), .busy_o(busy), .dout_o(dout), .preempt_o(preempt)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = idle), rotating pointer, hold age.
  int m_owner, m_ptr, m_sel, m_hold;
  bit m_pre, m_dout;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int i = 0; i < 4; i++)
      if (r[(from + i) % 4]) return (from + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0; m_pre = 0; m_dout = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    int w;
    m_pre = 0;
    if (m_owner < 0 || !r[m_owner]) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_sel = w; m_hold = 0; end
      else m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MAX_HOLD - 1) begin
        logic [3:0] others;
        others = r;
        others[m_owner] = 1'b0;
        w = pick(others, m_ptr);
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 4; m_sel = w; m_hold = 0; m_pre = 1; end
      end else m_hold++;
`endif
    end
    m_dout = (m_owner >= 0) ? d[m_owner] : 1'b0;
  endtask

  task automatic cmp_model();
    chk("grant", {4'h0, grant}, (m_owner >= 0) ? 8'(1 << m_owner) : 8'h0);
    chk("busy", {7'h0, busy}, {7'h0, m_owner >= 0});
    chk("sel", {6'h0, sel}, 8'(m_sel));
    chk("dout", {7'h0, dout}, {7'h0, m_dout});
    chk("preempt", {7'h0, preempt}, {7'h0, m_pre});
  endtask

  // Apply one cycle of inputs, step the model, compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] d);
    req = r; din = d;
    model_step(r, d);
    @(posedge clk); #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; din = '0;
    model_reset();
    #3;
    chk("rst_grant", {4'h0, grant}, 8'h0);
    chk("rst_busy", {7'h0, busy}, 8'h0);
    chk("rst_sel", {6'h0, sel}, 8'h0);
    chk("rst_dout", {7'h0, dout}, 8'h0);
    chk("rst_preempt", {7'h0, preempt}, 8'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req, din, grant;
    logic       busy, dout;
  } vec_t;

  vec_t vt[16];

  initial begin
    // ptr starts at 0; each row is one clock, expectations hold just after its edge.
    vt[0]  = '{4'b1111, 4'b0001, 4'b0001, 1, 1};
    vt[1]  = '{4'b1111, 4'b0000, 4'b0001, 1, 0};
    vt[2]  = '{4'b1110, 4'b0010, 4'b0010, 1, 1};
    vt[3]  = '{4'b1100, 4'b0010, 4'b0100, 1, 0};
    vt[4]  = '{4'b1000, 4'b1000, 4'b1000, 1, 1};
    vt[5]  = '{4'b0001, 4'b1111, 4'b0001, 1, 1};
    vt[6]  = '{4'b0000, 4'b1111, 4'b0000, 0, 0};
    vt[7]  = '{4'b0100, 4'b0100, 4'b0100, 1, 1};
    vt[8]  = '{4'b0100, 4'b0100, 4'b0100, 1, 1};
    vt[9]  = '{4'b0000, 4'b0100, 4'b0000, 0, 0};
    vt[10] = '{4'b0000, 4'b1111, 4'b0000, 0, 0};
    vt[11] = '{4'b1011, 4'b1000, 4'b1000, 1, 1};
    vt[12] = '{4'b0111, 4'b1110, 4'b0001, 1, 0};
    vt[13] = '{4'b1110, 4'b0010, 4'b0010, 1, 1};
    vt[14] = '{4'b0100, 4'b1011, 4'b0100, 1, 0};
    vt[15] = '{4'b0000, 4'b1111, 4'b0000, 0, 0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = vt[i].req; din = vt[i].din;
      model_step(vt[i].req, vt[i].din);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_grant", i), {4'h0, grant}, {4'h0, vt[i].grant});
      chk($sformatf("vec%0d_busy", i), {7'h0, busy}, {7'h0, vt[i].busy});
      chk($sformatf("vec%0d_dout", i), {7'h0, dout}, {7'h0, vt[i].dout});
      chk($sformatf("vec%0d_preempt", i), {7'h0, preempt}, 8'h0);
      if (vt[i].busy) chk($sformatf("vec%0d_sel", i), {6'h0, sel}, 8'($clog2(vt[i].grant)));
    end

    // Asynchronous reset while requester 3 holds the grant.
    cycle(4'b1000, 4'b1000);
    chk("r3_grant", {4'h0, grant}, 8'h08);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_grant", {4'h0, grant}, 8'h0);
    chk("async_busy", {7'h0, busy}, 8'h0);
    chk("async_dout", {7'h0, dout}, 8'h0);
    #2 rst_n = 1'b1;
    cycle(4'b1000, 4'b1000);
    chk("post_rst_grant", {4'h0, grant}, 8'h08);
    cycle(4'b0000, 4'b0000);
    // ptr restarted from 0 and moved to 0 again after granting 3: full request picks 0.
    cycle(4'b1111, 4'b0000);
    chk("post_rst_ptr", {4'h0, grant}, 8'h01);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    for (int c = 0; c < 17; c++) begin
      cycle(4'b0011, 4'b0000);
      chk("to_grant", {4'h0, grant}, (c < 8) ? 8'h01 : (c < 16) ? 8'h02 : 8'h01);
      chk("to_preempt", {7'h0, preempt}, {7'h0, (c == 8 || c == 16)});
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(4'b0010, 4'b0010);
      chk("solo_grant", {4'h0, grant}, 8'h02);
      chk("solo_preempt", {7'h0, preempt}, 8'h0);
    end
    // Holder drops exactly on the limit edge: plain release, no preempt.
    do_reset();
    for (int c = 0; c < 8; c++) cycle(4'b0011, 4'b0000);
    cycle(4'b0010, 4'b0000);
    chk("limit_rel_grant", {4'h0, grant}, 8'h02);
    chk("limit_rel_preempt", {7'h0, preempt}, 8'h0);
`else
    do_reset();
    for (int c = 0; c < 50; c++) begin
      cycle(4'b0011, 4'b0000);
      chk("nt_grant", {4'h0, grant}, 8'h01);
      chk("nt_preempt", {7'h0, preempt}, 8'h0);
    end
`endif

    // Random traffic with sticky requests and occasional mid-cycle resets.
    do_reset();
    begin
      logic [3:0] r;
      r = '0;
      for (int c = 0; c < 600; c++) begin
        for (int b = 0; b < 4; b++)
          if ($urandom_range(3) == 0) r[b] = ~r[b];
        cycle(r, 4'($urandom));
        if ($urandom_range(63) == 0) begin
          #2 rst_n = 1'b0;
          model_reset();
          #1;
          chk("rnd_rst_grant", {4'h0, grant}, 8'h0);
          chk("rnd_rst_dout", {7'h0, dout}, 8'h0);
          #2 rst_n = 1'b1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
